// File: rtl/irrigation_sequencer.sv
// Valve sequencer: turns divider timebases into tick enables and runs timed drip/spray doses,
// tank refill and post-dose cooldown, with a sticky sensor-conflict alarm.
module irrigation_sequencer #(
  parameter int unsigned DRIP_TICKS     = 8,
  parameter int unsigned SPRAY_TICKS    = 4,
  parameter int unsigned COOLDOWN_TICKS = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clock_Got,
  input  logic       clock_Asp,
  input  logic       soil_dry,
  input  logic       air_hot,
  input  logic       tank_low,
  input  logic       tank_high,
  output logic       valve_got,
  output logic       valve_asp,
  output logic       valve_fill,
  output logic       busy,
  output logic       error,
  output logic [1:0] mode_code
);

  localparam logic [7:0] DripLoad  = 8'(DRIP_TICKS);
  localparam logic [7:0] SprayLoad = 8'(SPRAY_TICKS);
  localparam logic [7:0] CoolLoad  = 8'(COOLDOWN_TICKS);

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StDrip,
    StSpray,
    StHold,
    StError
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic got_d1_q, got_d2_q, asp_d1_q, asp_d2_q;
  logic tick_got, tick_asp, tick_dose, conflict;

  logic       valve_got_d, valve_asp_d, valve_fill_d, busy_d, error_d;
  logic [1:0] mode_code_d;

  // Edge detectors preload the live level during reset so release never fakes a rising edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      got_d1_q <= clock_Got;
      got_d2_q <= clock_Got;
      asp_d1_q <= clock_Asp;
      asp_d2_q <= clock_Asp;
    end else begin
      got_d1_q <= clock_Got;
      got_d2_q <= got_d1_q;
      asp_d1_q <= clock_Asp;
      asp_d2_q <= asp_d1_q;
    end
  end

  assign tick_got  = got_d1_q & ~got_d2_q;
  assign tick_asp  = asp_d1_q & ~asp_d2_q;
  assign tick_dose = (state_q == StDrip) ? tick_got : tick_asp;
  assign conflict  = tank_low & tank_high;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (conflict) begin
          state_d = StError;
          cnt_d   = 8'd0;
        end else if (tank_low) begin
          state_d = StFill;
          cnt_d   = 8'd0;
        end else if (soil_dry && air_hot) begin
          state_d = StDrip;
          cnt_d   = DripLoad;
        end else if (soil_dry) begin
          state_d = StSpray;
          cnt_d   = SprayLoad;
        end
      end
      StFill: begin
        if (conflict) begin
          state_d = StError;
          cnt_d   = 8'd0;
        end else if (tank_high) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end
      end
      StDrip, StSpray: begin
        if (conflict) begin
          state_d = StError;
          cnt_d   = 8'd0;
        end else if (tank_low) begin
          state_d = StFill;
          cnt_d   = 8'd0;
        end else if (tick_dose && cnt_q == 8'd1) begin
          state_d = StHold;
          cnt_d   = CoolLoad;
        end else if (tick_dose) begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StHold: begin
        if (conflict) begin
          state_d = StError;
          cnt_d   = 8'd0;
        end else if (tick_asp && cnt_q == 8'd1) begin
          state_d = StIdle;
          cnt_d   = 8'd0;
        end else if (tick_asp) begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StError: begin
        state_d = StError;
        cnt_d   = 8'd0;
      end
      default: begin
        state_d = StError;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    valve_got_d  = (state_d == StDrip);
    valve_asp_d  = (state_d == StSpray);
    valve_fill_d = (state_d == StFill);
    busy_d       = (state_d != StIdle);
    error_d      = (state_d == StError);
    mode_code_d  = 2'b00;
    unique case (state_d)
      StFill:  mode_code_d = 2'b01;
      StDrip:  mode_code_d = 2'b10;
      StSpray: mode_code_d = 2'b11;
      default: mode_code_d = 2'b00;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      valve_got  <= 1'b0;
      valve_asp  <= 1'b0;
      valve_fill <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
      mode_code  <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valve_got  <= valve_got_d;
      valve_asp  <= valve_asp_d;
      valve_fill <= valve_fill_d;
      busy       <= busy_d;
      error      <= error_d;
      mode_code  <= mode_code_d;
    end
  end

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Randomized and directed bench for irrigation_sequencer against a dose-level reference model.
module tb_irrigation_sequencer;

  localparam int DRIP  = 3;
  localparam int SPRAY = 2;
  localparam int COOL  = 1;

  localparam int PH_IDLE  = 0;
  localparam int PH_FILL  = 1;
  localparam int PH_DRIP  = 2;
  localparam int PH_SPRAY = 3;
  localparam int PH_HOLD  = 4;
  localparam int PH_ERR   = 5;

  logic       clock = 1'b0;
  logic       reset, clock_Got, clock_Asp, soil_dry, air_hot, tank_low, tank_high;
  logic       valve_got, valve_asp, valve_fill, busy, error;
  logic [1:0] mode_code;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: activity phase, edges still owed, and last two timebase samples.
  int m_ph, m_rem;
  bit m_g1, m_g2, m_a1, m_a2;

  bit auto_tb = 1'b1;
  int got_half, asp_half, got_cnt, asp_cnt;

  irrigation_sequencer #(
    .DRIP_TICKS    (DRIP),
    .SPRAY_TICKS   (SPRAY),
    .COOLDOWN_TICKS(COOL)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .clock_Got (clock_Got),
    .clock_Asp (clock_Asp),
    .soil_dry  (soil_dry),
    .air_hot   (air_hot),
    .tank_low  (tank_low),
    .tank_high (tank_high),
    .valve_got (valve_got),
    .valve_asp (valve_asp),
    .valve_fill(valve_fill),
    .busy      (busy),
    .error     (error),
    .mode_code (mode_code)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit tg, ta, cf;
    if (reset) begin
      m_ph = PH_IDLE;
      m_rem = 0;
      m_g1 = clock_Got;
      m_g2 = clock_Got;
      m_a1 = clock_Asp;
      m_a2 = clock_Asp;
      return;
    end
    tg = m_g1 & ~m_g2;
    ta = m_a1 & ~m_a2;
    cf = tank_low & tank_high;
    if (m_ph != PH_ERR && cf) begin
      m_ph = PH_ERR;
      m_rem = 0;
    end else begin
      case (m_ph)
        PH_IDLE:
          if (tank_low) m_ph = PH_FILL;
          else if (soil_dry && air_hot) begin m_ph = PH_DRIP; m_rem = DRIP; end
          else if (soil_dry) begin m_ph = PH_SPRAY; m_rem = SPRAY; end
        PH_FILL: if (tank_high) m_ph = PH_IDLE;
        PH_DRIP, PH_SPRAY:
          if (tank_low) begin
            m_ph = PH_FILL;
            m_rem = 0;
          end else if ((m_ph == PH_DRIP) ? tg : ta) begin
            m_rem--;
            if (m_rem == 0) begin m_ph = PH_HOLD; m_rem = COOL; end
          end
        PH_HOLD:
          if (ta) begin
            m_rem--;
            if (m_rem == 0) m_ph = PH_IDLE;
          end
        default: ;
      endcase
    end
    m_g2 = m_g1;
    m_g1 = clock_Got;
    m_a2 = m_a1;
    m_a1 = clock_Asp;
  endtask

  task automatic compare_outputs();
    int exp_mode;
    exp_mode = (m_ph == PH_FILL) ? 1 : (m_ph == PH_DRIP) ? 2 : (m_ph == PH_SPRAY) ? 3 : 0;
    check_eq("valve_got", int'(valve_got), int'(m_ph == PH_DRIP));
    check_eq("valve_asp", int'(valve_asp), int'(m_ph == PH_SPRAY));
    check_eq("valve_fill", int'(valve_fill), int'(m_ph == PH_FILL));
    check_eq("busy", int'(busy), int'(m_ph != PH_IDLE));
    check_eq("error", int'(error), int'(m_ph == PH_ERR));
    check_eq("mode_code", int'(mode_code), exp_mode);
    if (int'(valve_got) + int'(valve_asp) + int'(valve_fill) > 1)
      check_eq("one_valve", int'(valve_got) + int'(valve_asp) + int'(valve_fill), 1);
  endtask

  // One clock: advance timebases at the negedge, step model at posedge, compare at negedge.
  task automatic run_cycle();
    if (auto_tb) begin
      got_cnt++;
      if (got_cnt >= got_half) begin got_cnt = 0; clock_Got = ~clock_Got; end
      asp_cnt++;
      if (asp_cnt >= asp_half) begin asp_cnt = 0; clock_Asp = ~clock_Asp; end
    end
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_outputs();
  endtask

  task automatic reset_dut(input int cycles);
    reset = 1'b1;
    repeat (cycles) run_cycle();
    reset = 1'b0;
  endtask

  task automatic wait_phase(input string tag, input int ph, input int limit);
    int n;
    n = 0;
    while (m_ph != ph && n < limit) begin
      run_cycle();
      n++;
    end
    if (m_ph != ph) check_eq({tag, "_timeout"}, m_ph, ph);
  endtask

  initial begin
    reset = 1'b1;
    clock_Got = 1'b0; clock_Asp = 1'b0;
    soil_dry = 1'b0; air_hot = 1'b0; tank_low = 1'b0; tank_high = 1'b0;
    got_half = 4; asp_half = 6; got_cnt = 0; asp_cnt = 0;
    @(negedge clock);

    // Release reset while the drip timebase is high: no tick may appear.
    auto_tb = 1'b0;
    clock_Got = 1'b1;
    reset_dut(3);
    check_eq("rst_mode", int'(mode_code), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_cnt", int'(dut.cnt_q), 0);
    repeat (3) run_cycle();
    auto_tb = 1'b1;

    // Full drip dose, then cooldown back to idle.
    soil_dry = 1'b1; air_hot = 1'b1;
    wait_phase("drip_enter", PH_DRIP, 10);
    soil_dry = 1'b0; air_hot = 1'b0;
    wait_phase("drip_done", PH_IDLE, 300);
    check_eq("drip_idle_busy", int'(busy), 0);

    // Sprinkler dose.
    soil_dry = 1'b1; air_hot = 1'b0;
    wait_phase("spray_enter", PH_SPRAY, 10);
    check_eq("spray_mode", int'(mode_code), 3);
    soil_dry = 1'b0;
    wait_phase("spray_done", PH_IDLE, 300);

    // Abort a drip on its second tick.
    soil_dry = 1'b1; air_hot = 1'b1;
    wait_phase("abort_enter", PH_DRIP, 10);
    soil_dry = 1'b0;
    begin
      int n;
      n = 0;
      while (!(m_ph == PH_DRIP && m_rem == DRIP - 1 && m_g1 && !m_g2) && n < 300) begin
        run_cycle();
        n++;
      end
      if (n >= 300) check_eq("abort_timeout", n, 0);
    end
    tank_low = 1'b1;
    run_cycle();
    check_eq("abort_got", int'(valve_got), 0);
    check_eq("abort_fill", int'(valve_fill), 1);
    check_eq("abort_mode", int'(mode_code), 1);
    tank_low = 1'b0; tank_high = 1'b1;
    run_cycle();
    check_eq("refill_idle", int'(busy), 0);
    tank_high = 1'b0;

    // Sticky conflict alarm.
    tank_low = 1'b1; tank_high = 1'b1;
    run_cycle();
    check_eq("conflict_err", int'(error), 1);
    tank_low = 1'b0; tank_high = 1'b0;
    repeat (20) run_cycle();
    check_eq("conflict_sticky", int'(error), 1);
    reset_dut(1);
    check_eq("conflict_clear", int'(error), 0);

    // Reset mid-spray closes valves one cycle later.
    soil_dry = 1'b1; air_hot = 1'b0;
    wait_phase("spray2_enter", PH_SPRAY, 10);
    reset = 1'b1;
    run_cycle();
    check_eq("midrst_asp", int'(valve_asp), 0);
    check_eq("midrst_mode", int'(mode_code), 0);
    check_eq("midrst_cnt", int'(dut.cnt_q), 0);
    reset = 1'b0;

    // Randomized episodes with varying timebase periods.
    for (int ep = 0; ep < 8; ep++) begin
      got_half = $urandom_range(2, 9);
      asp_half = $urandom_range(2, 12);
      reset_dut($urandom_range(1, 3));
      for (int c = 0; c < 1500; c++) begin
        soil_dry = ($urandom_range(0, 7) != 0);
        air_hot  = $urandom_range(0, 1);
        tank_low = ($urandom_range(0, 39) == 0);
        tank_high = ($urandom_range(0, 5) == 0) && !tank_low;
        if ($urandom_range(0, 1999) == 0) begin tank_low = 1'b1; tank_high = 1'b1; end
        reset = ($urandom_range(0, 499) == 0);
        run_cycle();
      end
      reset = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
